// File: rtl/ads868x_spi_responder.sv
// ads868x_spi_responder
//   Device-side emulation of the ADS868x SPI register/data protocol. The
//   master clocks in a 32-bit command frame:
//     {opcode[7:0], addr[7:0], data[15:0]}
//   While it does so, the responder shifts out the reply that was staged by
//   the previous frame.
//
//   Opcodes:
//     D0  write data to reg[addr]
//     C8  read half-word; the next frame returns {reg[addr], 16'h0}
//     48  read byte; the next frame returns {reg[addr][7:0], 24'h0}
//     00 or any other value  NOP; the next frame returns {sample_hold, 16'h0}
//
//   Valid register addresses are 0x00, 0x04, 0x08, 0x0C, 0x10 and 0x14.
//
//   Optional build macro ADS_RESP_STATUS_EN: when it is defined, the low 16
//   bits of every reply carry a status word instead of zero:
//     {8'hA5, frame_cnt[3:0], last_err, 1'b0, pending[1:0]}
//
// Ports
//   clk_ref       system clock; at least 8x the spi_sclk frequency
//   sys_rst       synchronous, active-high reset
//   spi_csn       frame select from the master, active low (async)
//   spi_sclk      serial clock from the master, idles low (async)
//   spi_sdi       command bits from the master, MSB first (async)
//   spi_sdo       reply bits to the master, MSB first
//   spi_rvs       high while idle with a reply staged; low during a frame
//   sample_in     parallel ADC sample
//   sample_valid  qualifies sample_in
//   conv_start    one-cycle pulse on each detected spi_csn fall
//   reg_wr        one-cycle pulse when a valid write frame commits
//   reg_addr      address of the last decoded command
//   reg_wdata     data field of the last decoded command
//   cmd_err       one-cycle pulse on a bad address or an aborted frame
//   fsm_state     current state (0 idle, 1 shift, 2 commit), for observation
//
// Handshake: spi_rvs is a plain level status. It is high only in IDLE, when
// a reply is staged. It drops for the whole frame plus the commit cycle.
module ads868x_spi_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] REG_RST_14  = 16'h0000
) (
  input  logic        clk_ref,
  input  logic        sys_rst,
  input  logic        spi_csn,
  input  logic        spi_sclk,
  input  logic        spi_sdi,
  output logic        spi_sdo,
  output logic        spi_rvs,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        conv_start,
  output logic        reg_wr,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        cmd_err,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] PEND_NOP  = 2'd0;
  localparam logic [1:0] PEND_HW   = 2'd1;
  localparam logic [1:0] PEND_BYTE = 2'd2;

  localparam logic [7:0] OP_WRITE = 8'hD0;
  localparam logic [7:0] OP_RD_HW = 8'hC8;
  localparam logic [7:0] OP_RD_BY = 8'h48;

  // ---------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] csn_sync, sclk_sync, sdi_sync;
  logic                   csn_d, sclk_d;
  logic                   csn_s, sclk_s, sdi_s;
  logic                   csn_fall, csn_rise, sclk_rise, sclk_fall;

  always_ff @(posedge clk_ref) begin
    if (sys_rst) begin
      // csn idles high; resetting it high avoids a false fall after reset.
      csn_sync  <= '1;
      sclk_sync <= '0;
      sdi_sync  <= '0;
      csn_d     <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
      csn_d     <= csn_s;
      sclk_d    <= sclk_s;
    end
  end

  assign csn_s  = csn_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  // sdi runs through the same number of stages as sclk, so it is sampled
  // at the same point relative to the pin edge.
  assign sdi_s  = sdi_sync[SYNC_STAGES-1];

  assign csn_fall  = csn_d & ~csn_s;
  assign csn_rise  = ~csn_d & csn_s;
  // sclk edges only count while the frame is selected.
  assign sclk_rise = ~sclk_d & sclk_s & ~csn_s;
  assign sclk_fall = sclk_d & ~sclk_s & ~csn_s;

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  state_t      state, state_nxt;
  logic [31:0] rx_shift, tx_shift;
  logic [5:0]  bit_cnt;
  logic [15:0] sample_hold;
  logic [1:0]  pending;
  logic [2:0]  pend_idx;
  logic [15:0] regs [6];

  // ---------------------------------------------------------------------
  // Command decode of the received frame
  // ---------------------------------------------------------------------
  logic [7:0]  dec_op, dec_addr;
  logic [15:0] dec_data;
  logic [2:0]  dec_idx;
  logic        dec_cmd, dec_addr_ok, err_now;

  always_comb begin
    dec_op      = rx_shift[31:24];
    dec_addr    = rx_shift[23:16];
    dec_data    = rx_shift[15:0];
    dec_idx     = rx_shift[20:18];
    dec_cmd     = (dec_op == OP_WRITE) || (dec_op == OP_RD_HW) ||
                  (dec_op == OP_RD_BY);
    dec_addr_ok = (dec_addr[1:0] == 2'b00) && (dec_addr[7:5] == 3'b000) &&
                  (dec_addr[4:2] <= 3'd5);
    err_now     = ((state == ST_SHIFT) && csn_rise && (bit_cnt != 6'd32)) ||
                  ((state == ST_COMMIT) && dec_cmd && !dec_addr_ok);
  end

  // ---------------------------------------------------------------------
  // Reply word staged at the start of a frame
  // ---------------------------------------------------------------------
  logic [15:0] status_word, sample_now, rd_word;
  logic [31:0] tx_load;

`ifdef ADS_RESP_STATUS_EN
  logic [3:0] frame_cnt;
  logic       last_err;

  always_ff @(posedge clk_ref) begin
    if (sys_rst) begin
      frame_cnt <= 4'd0;
      last_err  <= 1'b0;
    end else begin
      if (state == ST_COMMIT) frame_cnt <= frame_cnt + 4'd1;
      if (err_now)
        last_err <= 1'b1;
      else if (state == ST_COMMIT)
        last_err <= 1'b0;
    end
  end

  assign status_word = {8'hA5, frame_cnt, last_err, 1'b0, pending};
`else
  assign status_word = 16'h0000;
`endif

  always_comb begin
    // A sample arriving in the same cycle as the csn fall wins.
    sample_now = sample_valid ? sample_in : sample_hold;
    rd_word    = (pend_idx <= 3'd5) ? regs[pend_idx] : 16'h0000;
    case (pending)
      PEND_HW:   tx_load = {rd_word, status_word};
      PEND_BYTE: tx_load = {rd_word[7:0], 8'h00, status_word};
      default:   tx_load = {sample_now, status_word};
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_ref) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (csn_fall) state_nxt = ST_SHIFT;
      ST_SHIFT:  if (csn_rise)
                   state_nxt = (bit_cnt == 6'd32) ? ST_COMMIT : ST_IDLE;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    spi_rvs   = (state == ST_IDLE);
    fsm_state = state;
  end

  // ---------------------------------------------------------------------
  // Shift registers, register file and pulse outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_ref) begin
    if (sys_rst) begin
      spi_sdo     <= 1'b0;
      conv_start  <= 1'b0;
      reg_wr      <= 1'b0;
      reg_addr    <= 8'h00;
      reg_wdata   <= 16'h0000;
      cmd_err     <= 1'b0;
      rx_shift    <= 32'h0;
      tx_shift    <= 32'h0;
      bit_cnt     <= 6'd0;
      sample_hold <= 16'h0000;
      pending     <= PEND_NOP;
      pend_idx    <= 3'd0;
      for (int i = 0; i < 5; i++) regs[i] <= 16'h0000;
      regs[5]     <= REG_RST_14;
    end else begin
      conv_start <= 1'b0;
      reg_wr     <= 1'b0;
      cmd_err    <= err_now;
      if (sample_valid) sample_hold <= sample_in;

      case (state)
        ST_IDLE: begin
          if (csn_fall) begin
            conv_start <= 1'b1;
            bit_cnt    <= 6'd0;
            rx_shift   <= 32'h0;
            tx_shift   <= tx_load;
            spi_sdo    <= tx_load[31];
          end
        end
        ST_SHIFT: begin
          if (csn_rise) begin
            spi_sdo <= 1'b0;
            if (bit_cnt != 6'd32) pending <= PEND_NOP;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[30:0], sdi_s};
            // Saturate at 33 so an over-long frame still reads as aborted.
            if (bit_cnt != 6'd33) bit_cnt <= bit_cnt + 6'd1;
          end else if (sclk_fall) begin
            tx_shift <= {tx_shift[30:0], 1'b0};
            spi_sdo  <= tx_shift[30];
          end
        end
        ST_COMMIT: begin
          reg_addr  <= dec_addr;
          reg_wdata <= dec_data;
          pend_idx  <= dec_idx;
          pending   <= PEND_NOP;
          if (dec_cmd && dec_addr_ok) begin
            case (dec_op)
              OP_WRITE: begin
                regs[dec_idx] <= dec_data;
                reg_wr        <= 1'b1;
              end
              OP_RD_HW: pending <= PEND_HW;
              default:  pending <= PEND_BYTE;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule
